// File: rtl/crc_frame_append.sv
// Transmit framing stage: passes payload words through, feeds them to an external
// lfsr_crc engine, then appends the engine's CRC (MS word first) and clears the engine.
module crc_frame_append #(
    parameter int BITWIDTH   = 8,
    parameter int LFSR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BITWIDTH-1:0]   s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [BITWIDTH-1:0]   m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [BITWIDTH-1:0]   crc_data_o,
    output logic                  crc_valid_o,
    output logic                  crc_clr_n_o,
    input  logic [LFSR_WIDTH-1:0] crc_i
);

    // Both streams use valid/ready: a word moves on a cycle where valid and ready are
    // both high at the rising edge; a producer holding valid keeps its data stable.

    localparam int CRC_WORDS = LFSR_WIDTH / BITWIDTH;
    localparam int CW        = (CRC_WORDS > 1) ? $clog2(CRC_WORDS) : 1;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        PASS   = 2'd1,
        WAIT   = 2'd2,
        APPEND = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         cnt;
    logic [LFSR_WIDTH-1:0] shreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            if (state == WAIT) begin
                shreg <= crc_i;
                cnt   <= CW'(CRC_WORDS - 1);
            end else if (state == APPEND && m_ready) begin
                shreg <= shreg << BITWIDTH;
                cnt   <= cnt - 1'b1;
            end
        end
    end

    // Outputs are forced to the CLEAR values while rst_n is low, even before the edge.
    always_comb begin
        state_nxt   = state;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        m_data      = shreg[LFSR_WIDTH-1 -: BITWIDTH];
        crc_data_o  = s_data;
        crc_valid_o = 1'b0;
        crc_clr_n_o = 1'b1;
        if (!rst_n) begin
            crc_clr_n_o = 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    crc_clr_n_o = 1'b0;
                    state_nxt   = PASS;
                end
                PASS: begin
                    m_data      = s_data;
                    m_valid     = s_valid;
                    s_ready     = m_ready;
                    crc_valid_o = s_valid & m_ready;
                    if (s_valid && m_ready && s_last) state_nxt = WAIT;
                end
                WAIT: begin
                    state_nxt = APPEND;
                end
                APPEND: begin
                    m_valid = 1'b1;
                    m_last  = (cnt == '0);
                    if (m_ready && cnt == '0) state_nxt = CLEAR;
                end
                default: state_nxt = CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_frame_append.sv
// Bench for crc_frame_append: an 8-bit CRC instance and a 32-bit CRC instance, each
// with its own lfsr_crc engine stand-in, checked against a whole-frame CRC model.
module tb_crc_frame_append;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, sel;
    logic [7:0] s_data;
    logic       s_valid, s_last, m_ready;

    logic       s_ready_a, m_valid_a, m_last_a, crc_valid_a, crc_clr_a;
    logic [7:0] m_data_a, crc_data_a, crc_a;
    logic       s_ready_b, m_valid_b, m_last_b, crc_valid_b, crc_clr_b;
    logic [7:0] m_data_b, crc_data_b;
    logic [31:0] crc_b;

    logic       s_valid_a, s_valid_b;
    assign s_valid_a = s_valid & ~sel;
    assign s_valid_b = s_valid & sel;

    logic       s_ready, m_valid, m_last, crc_valid, crc_clr;
    logic [7:0] m_data, crc_data;
    assign s_ready   = sel ? s_ready_b   : s_ready_a;
    assign m_valid   = sel ? m_valid_b   : m_valid_a;
    assign m_last    = sel ? m_last_b    : m_last_a;
    assign m_data    = sel ? m_data_b    : m_data_a;
    assign crc_valid = sel ? crc_valid_b : crc_valid_a;
    assign crc_data  = sel ? crc_data_b  : crc_data_a;
    assign crc_clr   = sel ? crc_clr_b   : crc_clr_a;

    crc_frame_append #(.BITWIDTH(8), .LFSR_WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid_a), .s_last(s_last), .s_ready(s_ready_a),
        .m_data(m_data_a), .m_valid(m_valid_a), .m_last(m_last_a), .m_ready(m_ready),
        .crc_data_o(crc_data_a), .crc_valid_o(crc_valid_a), .crc_clr_n_o(crc_clr_a),
        .crc_i(crc_a)
    );

    crc_frame_append #(.BITWIDTH(8), .LFSR_WIDTH(32)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid_b), .s_last(s_last), .s_ready(s_ready_b),
        .m_data(m_data_b), .m_valid(m_valid_b), .m_last(m_last_b), .m_ready(m_ready),
        .crc_data_o(crc_data_b), .crc_valid_o(crc_valid_b), .crc_clr_n_o(crc_clr_b),
        .crc_i(crc_b)
    );

    // CRC-8 poly 0x07 init 0, MSB first
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int b = 0; b < 8; b++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    // CRC-32 reflected form (poly 0x04C11DB7 reversed), init all-ones, output inverted
    function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    logic [7:0]  eng_a;
    logic [31:0] eng_b;
    always_ff @(posedge clk) begin
        if (!(rst_n && crc_clr_a)) eng_a <= 8'h00;
        else if (crc_valid_a)      eng_a <= crc8_step(eng_a, crc_data_a);
        if (!(rst_n && crc_clr_b)) eng_b <= 32'hFFFFFFFF;
        else if (crc_valid_b)      eng_b <= crc32_step(eng_b, crc_data_b);
    end
    assign crc_a = eng_a;
    assign crc_b = ~eng_b;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  frm[$];
    logic [8:0]  exp_q[$];
    logic [8:0]  out_log[$];
    int          rdy_mode = 0;
    logic        gap_chk  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] model_crc(input logic s32);
        logic [7:0]  c8;
        logic [31:0] c32;
        c8  = 8'h00;
        c32 = 32'hFFFFFFFF;
        foreach (frm[i]) begin
            c8  = crc8_step(c8, frm[i]);
            c32 = crc32_step(c32, frm[i]);
        end
        return s32 ? ~c32 : {24'h0, c8};
    endfunction

    task automatic push_expected(input logic s32);
        logic [31:0] c;
        int          n;
        c = model_crc(s32);
        n = s32 ? 4 : 1;
        foreach (frm[i]) exp_q.push_back({1'b0, frm[i]});
        for (int k = n - 1; k >= 0; k--) exp_q.push_back({(k == 0), c[k*8 +: 8]});
    endtask

    task automatic set_ascii_check();
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'(8'h31 + i));
    endtask

    task automatic send_frame(input logic s32, input int max_gap);
        sel = s32;
        push_expected(s32);
        for (int i = 0; i < frm.size(); i++) begin
            int   t;
            logic hs;
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    s_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            s_data  = frm[i];
            s_last  = (i == frm.size() - 1);
            s_valid = 1'b1;
            t  = 0;
            hs = 1'b0;
            while (!hs && t < 200) begin
                @(negedge clk);
                hs = s_ready;
                @(posedge clk); #1;
                t++;
            end
            chk("s_handshake", hs, 1'b1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial forever begin
        @(posedge clk); #2;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            2:       m_ready = 1'(($urandom_range(0, 1)));
            default: ;
        endcase
    end

    // Compare process: all DUT observation happens here, at the falling edge.
    initial begin
        logic       stall_prev, prev_last;
        logic [7:0] held;
        logic [8:0] e;
        int         clr_pend, cyc, last_cyc;
        stall_prev = 1'b0; prev_last = 1'b0; held = '0;
        clr_pend = 0; cyc = 0; last_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("reset_outputs", {s_ready, m_valid, m_last, crc_valid, crc_clr}, 0);
                stall_prev = 1'b0;
                prev_last  = 1'b0;
                clr_pend   = 0;
            end else begin
                chk("crc_valid", crc_valid, s_valid && s_ready);
                if (crc_valid) chk("crc_data", crc_data, s_data);
                if (stall_prev) chk("hold_stable", {m_valid, m_data}, {1'b1, held});
                stall_prev = m_valid && !m_ready;
                held       = m_data;
                if (clr_pend == 2) begin chk("clr_high", crc_clr, 1'b1); clr_pend = 0; end
                if (clr_pend == 1) begin chk("clr_low", crc_clr, 1'b0); clr_pend = 2; end
                if (s_valid && s_ready) begin
                    if (gap_chk && prev_last) chk("frame_gap", cyc - last_cyc, 4);
                    prev_last = s_last;
                    if (s_last) last_cyc = cyc;
                end
                if (m_valid && m_ready) begin
                    chk("out_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("m_data", m_data, e[7:0]);
                        chk("m_last", m_last, e[8]);
                    end
                    out_log.push_back({m_last, m_data});
                    if (m_last) clr_pend = 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        n_checks++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        rst_n = 1'b0; sel = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;

        // Model pins against published check values.
        frm.delete(); frm.push_back(8'h22);
        chk("model_crc8_22", model_crc(1'b0), 32'h000000EE);
        set_ascii_check();
        chk("model_crc32_check", model_crc(1'b1), 32'hCBF43926);

        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_clear_clr", crc_clr, 1'b0);
        chk("post_reset_clear_sready", s_ready, 1'b0);
        @(negedge clk);
        chk("post_reset_pass_clr", crc_clr, 1'b1);
        chk("post_reset_pass_sready", s_ready, 1'b1);
        @(posedge clk); #1;

        // 1: single-word 8-bit frame
        out_log.delete();
        frm.delete(); frm.push_back(8'h22);
        send_frame(1'b0, 0);
        drain();
        chk("t1_w0", out_log[0], 9'h022);
        chk("t1_w1", out_log[1], 9'h1EE);

        // 2: CRC-32 check string
        out_log.delete();
        set_ascii_check();
        send_frame(1'b1, 0);
        drain();
        chk("t2_len", out_log.size(), 13);
        chk("t2_p0", out_log[0], 9'h031);
        chk("t2_c0", out_log[9], 9'h0CB);
        chk("t2_c1", out_log[10], 9'h0F4);
        chk("t2_c2", out_log[11], 9'h039);
        chk("t2_c3", out_log[12], 9'h126);

        // 3: toggling back-pressure
        rdy_mode = 1;
        out_log.delete();
        frm.delete(); frm.push_back(8'h22);
        send_frame(1'b0, 0);
        drain();
        chk("t3_w0", out_log[0], 9'h022);
        chk("t3_w1", out_log[1], 9'h1EE);
        rdy_mode = 0;
        repeat (2) begin @(posedge clk); #1; end

        // 4: back-to-back frames
        out_log.delete();
        frm.delete(); frm.push_back(8'h22);
        send_frame(1'b0, 0);
        gap_chk = 1'b1;
        send_frame(1'b0, 0);
        gap_chk = 1'b0;
        drain();
        chk("t4_f1_crc", out_log[1], 9'h1EE);
        chk("t4_f2_crc", out_log[3], 9'h1EE);

        // 5: reset during APPEND, then a clean frame
        set_ascii_check();
        send_frame(1'b1, 0);
        rdy_mode = 3;
        m_ready  = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_append_valid", m_valid, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_valid_after_reset", m_valid, 1'b0);
        exp_q.delete();
        rdy_mode = 0;
        repeat (3) begin @(posedge clk); #1; end
        out_log.delete();
        set_ascii_check();
        send_frame(1'b1, 0);
        drain();
        chk("t5_len", out_log.size(), 13);
        chk("t5_c0", out_log[9], 9'h0CB);
        chk("t5_c3", out_log[12], 9'h126);

        // 6: idle gaps inside a frame
        out_log.delete();
        set_ascii_check();
        send_frame(1'b1, 3);
        drain();
        chk("t6_c0", out_log[9], 9'h0CB);
        chk("t6_c1", out_log[10], 9'h0F4);
        chk("t6_c2", out_log[11], 9'h039);
        chk("t6_c3", out_log[12], 9'h126);

        // Random frames on both widths with random back-pressure and gaps.
        rdy_mode = 2;
        for (int f = 0; f < 30; f++) begin
            logic s32;
            s32 = 1'(($urandom_range(0, 1)));
            if (s32 != sel) drain();
            frm.delete();
            repeat ($urandom_range(1, 6)) frm.push_back(8'($urandom_range(0, 255)));
            send_frame(s32, 2);
        end
        drain();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
